// File: rtl/fibonacci_lfsr_bank_if.sv
// Load/step handshake and output bus of the Fibonacci LFSR bank.
// The bank itself takes the slave modport; its driver takes the master modport.
interface fibonacci_lfsr_bank_if #(
  parameter int WIDTH = 20,
  parameter int NCH   = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                   en;
  logic                   load_valid;
  logic                   load_ready;
  logic [CHW-1:0]         load_ch;
  logic [WIDTH-1:0]       load_seed;
  logic [NCH*WIDTH-1:0]   r;
  logic                   r_valid;
  logic                   load_err;

  modport master (
    output en, load_valid, load_ch, load_seed,
    input  load_ready, r, r_valid, load_err
  );

  modport slave (
    input  en, load_valid, load_ch, load_seed,
    output load_ready, r, r_valid, load_err
  );
endinterface

// File: rtl/fibonacci_lfsr_bank.sv
// Bank of NCH Fibonacci LFSRs with run-time reseed and warm-up qualified output words.
// Optional zero-state recovery is compiled in with `define LFSR_LOCKUP_CHECK_EN.
module fibonacci_lfsr_lane #(
  parameter int               WIDTH    = 20,
  parameter logic [WIDTH-1:0] DEF_SEED = '1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             step,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_seed,
`ifdef LFSR_LOCKUP_CHECK_EN
  input  logic             relock,
  output logic             is_zero,
`endif
  output logic [WIDTH-1:0] r
);
  logic [WIDTH-1:0] s;
  logic             fb;

  if (WIDTH == 8) begin : g_t8
    assign fb = s[7] ^ s[5] ^ s[4] ^ s[3];
  end else if (WIDTH == 16) begin : g_t16
    assign fb = s[15] ^ s[14] ^ s[12] ^ s[3];
  end else if (WIDTH == 20) begin : g_t20
    assign fb = s[19] ^ s[16];
  end else if (WIDTH == 24) begin : g_t24
    assign fb = s[23] ^ s[22] ^ s[21] ^ s[16];
  end else begin : g_t32
    assign fb = s[31] ^ s[21] ^ s[1] ^ s[0];
  end

`ifdef LFSR_LOCKUP_CHECK_EN
  assign is_zero = (s == '0);
`endif

  // r is the MSB history, so after WIDTH steps it holds the seed verbatim
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      s <= DEF_SEED;
      r <= '0;
    end else if (ld) begin
      s <= (ld_seed == '0) ? WIDTH'(1) : ld_seed;
      r <= '0;
`ifdef LFSR_LOCKUP_CHECK_EN
    end else if (relock) begin
      s <= DEF_SEED;
      r <= '0;
`endif
    end else if (step) begin
      s <= {s[WIDTH-2:0], fb};
      r <= {r[WIDTH-2:0], s[WIDTH-1]};
    end
  end
endmodule

module fibonacci_lfsr_bank #(
  parameter int          WIDTH       = 20,
  parameter int          NCH         = 4,
  parameter logic [31:0] SEED        = 32'hDEADBEEF,
  parameter logic [31:0] SEED_STRIDE = 32'h9E3779B9
) (
  input  logic                   CLK,
  input  logic                   nRST,
`ifdef LFSR_LOCKUP_CHECK_EN
  output logic                   lockup,
`endif
  fibonacci_lfsr_bank_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 20 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("fibonacci_lfsr_bank: WIDTH must be 8, 16, 20, 24 or 32");
  end
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("fibonacci_lfsr_bank: NCH must be 1..16");
  end

  typedef enum logic [1:0] {WARM, RUN, LOAD} state_t;

  state_t                      state;
  logic [CW-1:0]               warm_cnt;
  logic                        load_ready_q, r_valid_q, load_err_q;
  logic                        accept, ch_ok, step;
  logic [NCH-1:0]              ld;
  logic [NCH-1:0][WIDTH-1:0]   r_w;

  assign accept = bus.load_valid & load_ready_q;
  // widen before comparing so a power-of-two NCH is not a constant compare
  assign ch_ok  = 32'(bus.load_ch) < 32'(NCH);
  assign step   = bus.en & ~accept & (state != LOAD);

  assign bus.load_ready = load_ready_q;
  assign bus.r_valid    = r_valid_q;
  assign bus.load_err   = load_err_q;
  assign bus.r          = r_w;

`ifdef LFSR_LOCKUP_CHECK_EN
  logic [NCH-1:0] zero, relock;
  logic           lock_any;
  logic           lockup_q;
  // a channel being loaded this cycle is repaired by the load itself
  assign relock   = zero & ~ld;
  assign lock_any = |relock;
  assign lockup   = lockup_q;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    localparam logic [31:0]      SUM = SEED + 32'(i) * SEED_STRIDE;
    localparam logic [WIDTH-1:0] RAW = SUM[WIDTH-1:0];
    localparam logic [WIDTH-1:0] DEF = (RAW == '0) ? WIDTH'(1) : RAW;

    assign ld[i] = accept & ch_ok & (32'(bus.load_ch) == 32'(i));

    fibonacci_lfsr_lane #(.WIDTH(WIDTH), .DEF_SEED(DEF)) u_lane (
      .CLK     (CLK),
      .nRST    (nRST),
      .step    (step),
      .ld      (ld[i]),
      .ld_seed (bus.load_seed),
`ifdef LFSR_LOCKUP_CHECK_EN
      .relock  (relock[i]),
      .is_zero (zero[i]),
`endif
      .r       (r_w[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= WARM;
      warm_cnt     <= '0;
      load_ready_q <= 1'b0;
      r_valid_q    <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef LFSR_LOCKUP_CHECK_EN
      lockup_q     <= 1'b0;
`endif
    end else begin
      load_err_q <= 1'b0;
`ifdef LFSR_LOCKUP_CHECK_EN
      lockup_q   <= lock_any;
`endif
      if (accept) begin
        state        <= LOAD;
        load_ready_q <= 1'b0;
        r_valid_q    <= 1'b0;
        load_err_q   <= ~ch_ok;
`ifdef LFSR_LOCKUP_CHECK_EN
      end else if (lock_any) begin
        state        <= WARM;
        warm_cnt     <= '0;
        load_ready_q <= 1'b1;
        r_valid_q    <= 1'b0;
`endif
      end else begin
        load_ready_q <= 1'b1;
        case (state)
          LOAD: begin
            state    <= WARM;
            warm_cnt <= '0;
          end
          WARM: if (bus.en) begin
            if (warm_cnt != CW'(WIDTH)) warm_cnt <= warm_cnt + CW'(1);
            // valid rises on the same edge that shifts in the last seed bit
            if (warm_cnt == CW'(WIDTH - 1)) begin
              state     <= RUN;
              r_valid_q <= 1'b1;
            end
          end
          RUN:     r_valid_q <= 1'b1;
          default: state     <= WARM;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fibonacci_lfsr_bank.sv
// Directed checks of the LFSR bank: a 4x20 bank driven from a vector table,
// plus hand sequences on a 1x8 bank for the full period and the bad-channel load.
module tb_fibonacci_lfsr_bank;
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  fibonacci_lfsr_bank_if #(.WIDTH(20), .NCH(4)) bus_a ();
  fibonacci_lfsr_bank_if #(.WIDTH(8),  .NCH(1)) bus_b ();

`ifdef LFSR_LOCKUP_CHECK_EN
  logic lockup_a, lockup_b;
`endif

  fibonacci_lfsr_bank #(.WIDTH(20), .NCH(4)) dut_a (
    .CLK    (CLK),
    .nRST   (nRST),
`ifdef LFSR_LOCKUP_CHECK_EN
    .lockup (lockup_a),
`endif
    .bus    (bus_a.slave)
  );

  fibonacci_lfsr_bank #(.WIDTH(8), .NCH(1), .SEED(32'h1)) dut_b (
    .CLK    (CLK),
    .nRST   (nRST),
`ifdef LFSR_LOCKUP_CHECK_EN
    .lockup (lockup_b),
`endif
    .bus    (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        lv;
    logic [1:0]  ch;
    logic [19:0] seed;
    int          cyc;
    logic [79:0] exp_r;
    logic [79:0] mask;
    logic        exp_v;
    logic        exp_rdy;
  } vec_t;

  function automatic vec_t v(logic rst, logic en, logic lv, logic [1:0] ch, logic [19:0] seed,
                             int cyc, logic [79:0] exp_r, logic [79:0] mask,
                             logic exp_v, logic exp_rdy);
    vec_t t;
    t.rst = rst; t.en = en; t.lv = lv; t.ch = ch; t.seed = seed; t.cyc = cyc;
    t.exp_r = exp_r; t.mask = mask; t.exp_v = exp_v; t.exp_rdy = exp_rdy;
    return t;
  endfunction

  vec_t tv[$];

  initial begin
    logic [79:0] seeds, half, all, m0, m2, st21, ld21;
    int k;

    seeds = {20'h42C1A, 20'hCB261, 20'h538A8, 20'hDBEEF};
    half  = {20'h2160D, 20'h65930, 20'h29C54, 20'h6DF77};
    st21  = {20'h85834, 20'h964C3, 20'hA7151, 20'hB7DDE};
    ld21  = {20'h85834, 20'h00000, 20'hA7151, 20'hB7DDE};
    all   = '1;
    m0    = {60'h0, 20'hFFFFF};
    m2    = {20'h0, 20'hFFFFF, 40'h0};

    //         rst en lv ch seed      cyc exp_r                              mask v  rdy
    tv.push_back(v(0, 1, 0, 0, 20'h0,     1, {20'h0, 20'h1, 20'h0, 20'h1},   all, 0, 1));
    tv.push_back(v(0, 0, 0, 0, 20'h0,     5, {20'h0, 20'h1, 20'h0, 20'h1},   all, 0, 1));
    tv.push_back(v(0, 1, 0, 0, 20'h0,    18, half,                           all, 0, 1));
    tv.push_back(v(0, 1, 0, 0, 20'h0,     1, seeds,                          all, 1, 1));
    tv.push_back(v(0, 1, 0, 0, 20'h0,     1, st21,                           all, 1, 1));
    tv.push_back(v(0, 1, 1, 2, 20'h0,     1, ld21,                           all, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 20'h0,     1, ld21,                           all, 0, 1));
    tv.push_back(v(0, 1, 0, 0, 20'h0,    19, 80'h0,                          m2,  0, 1));
    tv.push_back(v(0, 1, 0, 0, 20'h0,     1, {20'h0, 20'h1, 40'h0},          m2,  1, 1));
    tv.push_back(v(0, 1, 1, 0, 20'h12345, 1, 80'h0,                          m0,  0, 0));
    tv.push_back(v(0, 1, 0, 0, 20'h0,     1, 80'h0,                          m0,  0, 1));
    tv.push_back(v(0, 1, 0, 0, 20'h0,     3, 80'h0,                          m0,  0, 1));
    tv.push_back(v(0, 0, 0, 0, 20'h0,     2, 80'h0,                          m0,  0, 1));
    tv.push_back(v(0, 1, 0, 0, 20'h0,     2, {60'h0, 20'h2},                 m0,  0, 1));
    tv.push_back(v(1, 1, 0, 0, 20'h0,     1, 80'h0,                          all, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 20'h0,    19, half,                           all, 0, 1));
    tv.push_back(v(0, 1, 0, 0, 20'h0,     1, seeds,                          all, 1, 1));

    nRST = 1'b0;
    bus_a.en = 0; bus_a.load_valid = 0; bus_a.load_ch = '0; bus_a.load_seed = '0;
    bus_b.en = 0; bus_b.load_valid = 0; bus_b.load_ch = '0; bus_b.load_seed = '0;
    repeat (2) @(negedge CLK);
    chk("rst_r",     80'(bus_a.r),          80'h0);
    chk("rst_valid", 80'(bus_a.r_valid),    80'h0);
    chk("rst_ready", 80'(bus_a.load_ready), 80'h0);
    chk("rst_err",   80'(bus_a.load_err),   80'h0);
    chk("rst_r_b",   80'(bus_b.r),          80'h0);
    nRST = 1'b1;

    foreach (tv[i]) begin
      nRST             = ~tv[i].rst;
      bus_a.en         = tv[i].en;
      bus_a.load_valid = tv[i].lv;
      bus_a.load_ch    = tv[i].ch;
      bus_a.load_seed  = tv[i].seed;
      repeat (tv[i].cyc) @(negedge CLK);
      chk($sformatf("v%0d_r", i),     bus_a.r & tv[i].mask, tv[i].exp_r & tv[i].mask);
      chk($sformatf("v%0d_valid", i), 80'(bus_a.r_valid),    80'(tv[i].exp_v));
      chk($sformatf("v%0d_ready", i), 80'(bus_a.load_ready), 80'(tv[i].exp_rdy));
      chk($sformatf("v%0d_err", i),   80'(bus_a.load_err),   80'h0);
    end
    nRST = 1'b1;
    bus_a.en = 0; bus_a.load_valid = 0;

    // 8-bit bank, seed 1: s returns to 1 after 255 steps, seen in r 8 steps later
    bus_b.en = 1;
    k = 0;
    while (k < 400) begin
      @(negedge CLK);
      k++;
      if (k == 8) begin
        chk("b_r_at8",     80'(bus_b.r),       80'h01);
        chk("b_valid_at8", 80'(bus_b.r_valid), 80'h1);
      end
      if (k > 8 && bus_b.r == 8'h01) break;
    end
    chk("b_period", 80'(k), 80'd263);

    // out-of-range channel: state untouched, error pulse, re-warm from s = 8'h1C
    bus_b.load_valid = 1; bus_b.load_ch = 1'b1; bus_b.load_seed = 8'h55;
    @(negedge CLK);
    chk("b_err",       80'(bus_b.load_err),   80'h1);
    chk("b_err_r",     80'(bus_b.r),          80'h01);
    chk("b_err_valid", 80'(bus_b.r_valid),    80'h0);
    chk("b_err_ready", 80'(bus_b.load_ready), 80'h0);
    bus_b.load_valid = 0;
    @(negedge CLK);
    chk("b_err_pulse", 80'(bus_b.load_err),   80'h0);
    chk("b_load_r",    80'(bus_b.r),          80'h01);
    chk("b_load_rdy",  80'(bus_b.load_ready), 80'h1);
    repeat (7) @(negedge CLK);
    chk("b_valid_7",   80'(bus_b.r_valid),    80'h0);
    @(negedge CLK);
    chk("b_r_8",       80'(bus_b.r),          80'h1C);
    chk("b_valid_8",   80'(bus_b.r_valid),    80'h1);
    bus_b.en = 0;

`ifdef LFSR_LOCKUP_CHECK_EN
    // zero state on channel 1 is repaired to its default seed
    force dut_a.g_lane[1].u_lane.s = 20'h0;
    #1 release dut_a.g_lane[1].u_lane.s;
    @(negedge CLK);
    chk("lk_pulse", 80'(lockup_a),      80'h1);
    chk("lk_valid", 80'(bus_a.r_valid), 80'h0);
    chk("lk_r1",    bus_a.r & {40'h0, 20'hFFFFF, 20'h0}, 80'h0);
    bus_a.en = 1;
    @(negedge CLK);
    chk("lk_clear", 80'(lockup_a), 80'h0);
    repeat (19) @(negedge CLK);
    chk("lk_seed1", bus_a.r & {40'h0, 20'hFFFFF, 20'h0}, {40'h0, 20'h538A8, 20'h0});
    chk("lk_valid2", 80'(bus_a.r_valid), 80'h1);
    bus_a.en = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
